// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: shares the memory port between cache read-miss fills and
// write-buffer drains. Reads check the write buffer first and are forwarded
// on a hit; a full buffer always drains first.
// Optional feature macro: WB_AGE_EN adds a drain-starvation counter that lets
// a waiting drain win over a memory read after AGE_LIMIT cycles.

`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef WORD_SIZE_BIT
`define WORD_SIZE_BIT 32
`endif

module wb_mem_arbiter #(
   parameter int unsigned ADDR_W    = `MEM_ADDR_SIZE,
   parameter int unsigned DATA_W    = `WORD_SIZE_BIT,
   parameter int unsigned AGE_LIMIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   // cache side
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   // write-buffer side
   input  logic              wb_pending,
   input  logic              wb_full,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_hit,
   input  logic [DATA_W-1:0] wb_hit_data,
   output logic              wb_read,
   output logic [ADDR_W-1:0] wb_lookup_addr,
   output logic              wb_addr_done,
   output logic              wb_done,
   // memory side
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ack,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned AGE_W   = 8;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_STORE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_ADDR = 3'd3,
      ST_WR_DATA = 3'd4,
      ST_RESP    = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [DATA_W-1:0]   data_q,  data_d;
   logic                age_expired;

`ifdef WB_AGE_EN
   logic [AGE_W-1:0]    age_q, age_d;

   // Count cycles a drain waits outside the write states; saturate at the limit.
   always_comb begin
      age_d = age_q;
      if (!wb_pending || (state_d == ST_WR_ADDR && state_q != ST_WR_ADDR)) begin
         age_d = '0;
      end else if (state_q != ST_WR_ADDR && state_q != ST_WR_DATA && age_q != AGE_MAX) begin
         age_d = age_q + AGE_W'(1);
      end
   end

   // Age counter register.
   always_ff @(posedge clk) begin
      if (reset) age_q <= '0;
      else       age_q <= age_d;
   end

   assign age_expired = (age_q == AGE_MAX);
`else
   // Legal AGE_LIMIT is never 0, so without the counter this is constant 0.
   assign age_expired = (AGE_MAX == AGE_W'(0));
`endif

   // State, latched read address and response word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next-state selection and latch updates.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (wb_pending && wb_full) begin
               state_d = ST_WR_ADDR;
            end else if (rd_req && wb_hit) begin
               data_d  = wb_hit_data;
               state_d = ST_RESP;
            end else if (rd_req && !age_expired) begin
               addr_d  = rd_addr;
               state_d = ST_RD_ADDR;
            end else if (wb_pending) begin
               state_d = ST_WR_ADDR;
            end
         end
         ST_RD_ADDR: begin
            if (mem_addr_ack) begin
               if (mem_ack) begin
                  data_d  = mem_rdata;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_RD_DATA;
               end
            end
         end
         ST_RD_DATA: begin
            if (mem_ack) begin
               data_d  = mem_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         ST_WR_ADDR: begin
            if (mem_addr_ack) begin
               state_d = mem_ack ? ST_IDLE : ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (mem_ack) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Lookup port follows the cache request directly.
   always_comb begin
      wb_read        = rd_req && (state_q == ST_IDLE);
      wb_lookup_addr = rd_addr;
   end

   // Memory command, strobes and response; all forced low while reset is high
   // so an abandoned transaction never pops the buffer or answers the cache.
   always_comb begin
      rd_valid     = 1'b0;
      rd_data      = '0;
      wb_addr_done = 1'b0;
      wb_done      = 1'b0;
      mem_cmd      = CMD_NONE;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (!reset) begin
         case (state_q)
            ST_RD_ADDR, ST_RD_DATA: begin
               mem_cmd  = CMD_LOAD;
               mem_addr = addr_q;
            end
            ST_WR_ADDR: begin
               mem_cmd      = CMD_STORE;
               mem_addr     = wb_addr;
               mem_wdata    = wb_data;
               wb_addr_done = mem_addr_ack;
               wb_done      = mem_addr_ack && mem_ack;
            end
            ST_WR_DATA: begin
               mem_cmd   = CMD_STORE;
               mem_addr  = wb_addr;
               mem_wdata = wb_data;
               wb_done   = mem_ack;
            end
            ST_RESP: begin
               rd_valid = 1'b1;
               rd_data  = data_q;
            end
            default: begin
               mem_cmd = CMD_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed testbench for wb_mem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are compared 1 time unit later, well before the next edge.

module tb_wb_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              wb_pending;
   logic              wb_full;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_hit;
   logic [DATA_W-1:0] wb_hit_data;
   logic              wb_read;
   logic [ADDR_W-1:0] wb_lookup_addr;
   logic              wb_addr_done;
   logic              wb_done;
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_addr_ack;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   wb_mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .AGE_LIMIT (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .wb_pending     (wb_pending),
      .wb_full        (wb_full),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .wb_hit         (wb_hit),
      .wb_hit_data    (wb_hit_data),
      .wb_read        (wb_read),
      .wb_lookup_addr (wb_lookup_addr),
      .wb_addr_done   (wb_addr_done),
      .wb_done        (wb_done),
      .mem_cmd        (mem_cmd),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_addr_ack   (mem_addr_ack),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   // Compare one observed value with its expected value and count it.
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive every input to its quiet value.
   task automatic quiet_inputs();
      rd_req       = 1'b0;
      rd_addr      = '0;
      wb_pending   = 1'b0;
      wb_full      = 1'b0;
      wb_addr      = '0;
      wb_data      = '0;
      wb_hit       = 1'b0;
      wb_hit_data  = '0;
      mem_addr_ack = 1'b0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned stores;
      int unsigned first_store;
      int unsigned valids;

      quiet_inputs();
      reset = 1'b1;

      // ---- reset and idle ----
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_eq("rst rd_valid",     64'(rd_valid),     64'd0);
      check_eq("rst rd_data",      64'(rd_data),      64'd0);
      check_eq("rst mem_cmd",      64'(mem_cmd),      64'd0);
      check_eq("rst mem_addr",     64'(mem_addr),     64'd0);
      check_eq("rst mem_wdata",    64'(mem_wdata),    64'd0);
      check_eq("rst wb_done",      64'(wb_done),      64'd0);
      check_eq("rst wb_addr_done", 64'(wb_addr_done), 64'd0);
      check_eq("rst wb_read",      64'(wb_read),      64'd0);
      tick();
      check_eq("idle mem_cmd", 64'(mem_cmd), 64'd0);

      // ---- plain drain, acks one cycle apart ----
      wb_pending = 1'b1;
      wb_addr    = 32'h40;
      wb_data    = 32'hDEAD;
      #1;
      check_eq("drain idle cmd", 64'(mem_cmd), 64'd0);
      tick();                                   // WR_ADDR
      check_eq("drain cmd",        64'(mem_cmd),      64'd2);
      check_eq("drain addr",       64'(mem_addr),     64'h40);
      check_eq("drain wdata",      64'(mem_wdata),    64'hDEAD);
      check_eq("drain no adone",   64'(wb_addr_done), 64'd0);
      mem_addr_ack = 1'b1;
      #1;
      check_eq("drain adone",      64'(wb_addr_done), 64'd1);
      check_eq("drain early done", 64'(wb_done),      64'd0);
      tick();                                   // WR_DATA
      mem_addr_ack = 1'b0;
      #1;
      check_eq("drain data adone", 64'(wb_addr_done), 64'd0);
      check_eq("drain data cmd",   64'(mem_cmd),      64'd2);
      check_eq("drain data wdata", 64'(mem_wdata),    64'hDEAD);
      mem_ack = 1'b1;
      #1;
      check_eq("drain done",       64'(wb_done),      64'd1);
      tick();                                   // IDLE, buffer popped
      mem_ack    = 1'b0;
      wb_pending = 1'b0;
      #1;
      check_eq("drain end cmd",    64'(mem_cmd),      64'd0);
      check_eq("drain end done",   64'(wb_done),      64'd0);
      check_eq("drain end addr",   64'(mem_addr),     64'd0);

      // ---- buffer-hit read ----
      rd_req      = 1'b1;
      rd_addr     = 32'h40;
      wb_hit      = 1'b1;
      wb_hit_data = 32'hDEAD;
      #1;
      check_eq("hit wb_read",  64'(wb_read),        64'd1);
      check_eq("hit lookup",   64'(wb_lookup_addr), 64'h40);
      check_eq("hit idle cmd", 64'(mem_cmd),        64'd0);
      tick();                                   // RESP
      check_eq("hit valid",    64'(rd_valid),       64'd1);
      check_eq("hit data",     64'(rd_data),        64'hDEAD);
      check_eq("hit resp cmd", 64'(mem_cmd),        64'd0);
      check_eq("hit resp rd",  64'(wb_read),        64'd0);
      rd_req = 1'b0;
      wb_hit = 1'b0;
      tick();                                   // IDLE
      check_eq("hit after valid", 64'(rd_valid),    64'd0);

      // ---- read miss beats a non-full pending drain ----
      rd_req     = 1'b1;
      rd_addr    = 32'h80;
      wb_pending = 1'b1;
      wb_addr    = 32'h44;
      wb_data    = 32'hBEEF;
      tick();                                   // RD_ADDR
      check_eq("miss cmd",  64'(mem_cmd),  64'd1);
      check_eq("miss addr", 64'(mem_addr), 64'h80);
      mem_addr_ack = 1'b1;
      mem_ack      = 1'b1;
      mem_rdata    = 32'h1234;
      tick();                                   // RESP
      mem_addr_ack = 1'b0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;
      #1;
      check_eq("miss valid",    64'(rd_valid), 64'd1);
      check_eq("miss data",     64'(rd_data),  64'h1234);
      check_eq("miss resp cmd", 64'(mem_cmd),  64'd0);
      rd_req = 1'b0;
      tick();                                   // IDLE
      check_eq("miss idle cmd", 64'(mem_cmd),  64'd0);
      tick();                                   // WR_ADDR
      check_eq("post store cmd",   64'(mem_cmd),   64'd2);
      check_eq("post store addr",  64'(mem_addr),  64'h44);
      check_eq("post store wdata", 64'(mem_wdata), 64'hBEEF);
      mem_addr_ack = 1'b1;
      mem_ack      = 1'b1;
      #1;
      check_eq("post store adone", 64'(wb_addr_done), 64'd1);
      check_eq("post store done",  64'(wb_done),      64'd1);
      tick();                                   // IDLE
      mem_addr_ack = 1'b0;
      mem_ack      = 1'b0;
      wb_pending   = 1'b0;
      #1;
      check_eq("post store end", 64'(mem_cmd), 64'd0);

      // ---- full buffer beats a read miss ----
      rd_req     = 1'b1;
      rd_addr    = 32'h88;
      wb_pending = 1'b1;
      wb_full    = 1'b1;
      wb_addr    = 32'h48;
      wb_data    = 32'h5555;
      tick();                                   // WR_ADDR
      check_eq("full cmd",  64'(mem_cmd),  64'd2);
      check_eq("full addr", 64'(mem_addr), 64'h48);
      check_eq("full rd",   64'(wb_read),  64'd0);
      mem_addr_ack = 1'b1;
      mem_ack      = 1'b1;
      #1;
      check_eq("full done", 64'(wb_done),  64'd1);
      tick();                                   // IDLE
      mem_addr_ack = 1'b0;
      mem_ack      = 1'b0;
      wb_pending   = 1'b0;
      wb_full      = 1'b0;
      #1;
      check_eq("full idle cmd", 64'(mem_cmd), 64'd0);
      check_eq("full idle rd",  64'(wb_read), 64'd1);
      tick();                                   // RD_ADDR
      check_eq("full load cmd",  64'(mem_cmd),  64'd1);
      check_eq("full load addr", 64'(mem_addr), 64'h88);
      mem_addr_ack = 1'b1;
      tick();                                   // RD_DATA
      mem_addr_ack = 1'b0;
      #1;
      check_eq("full rddata cmd", 64'(mem_cmd), 64'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h77;
      tick();                                   // RESP
      mem_ack   = 1'b0;
      mem_rdata = '0;
      rd_req    = 1'b0;
      #1;
      check_eq("full valid", 64'(rd_valid), 64'd1);
      check_eq("full data",  64'(rd_data),  64'h77);
      tick();                                   // IDLE

      // ---- reset during WR_DATA drops the store ----
      wb_pending = 1'b1;
      wb_addr    = 32'h50;
      wb_data    = 32'h1;
      tick();                                   // WR_ADDR
      mem_addr_ack = 1'b1;
      tick();                                   // WR_DATA
      mem_addr_ack = 1'b0;
      #1;
      check_eq("rstw cmd", 64'(mem_cmd), 64'd2);
      reset   = 1'b1;
      mem_ack = 1'b1;
      #1;
      check_eq("rstw no done", 64'(wb_done), 64'd0);
      tick();                                   // IDLE
      reset      = 1'b0;
      mem_ack    = 1'b0;
      wb_pending = 1'b0;
      #1;
      check_eq("rstw idle cmd",   64'(mem_cmd),  64'd0);
      check_eq("rstw idle valid", 64'(rd_valid), 64'd0);
      tick();

      // ---- continuous missing reads with a drain waiting ----
      rd_req      = 1'b1;
      rd_addr     = 32'h90;
      wb_pending  = 1'b1;
      wb_addr     = 32'h60;
      wb_data     = 32'h66;
      mem_rdata   = 32'hAA;
      stores      = 0;
      first_store = 99;
      valids      = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         mem_addr_ack = (mem_cmd != 2'd0);
         mem_ack      = (mem_cmd != 2'd0);
         #1;
         if (rd_valid) valids++;
         if (mem_cmd == 2'd2) begin
            if (stores == 0) first_store = cyc;
            stores++;
         end
         if (wb_done) wb_pending = 1'b0;
         tick();
      end
`ifdef WB_AGE_EN
      check_eq("age stores",      64'(stores),      64'd1);
      check_eq("age first store", 64'(first_store), 64'd4);
      check_eq("age valids",      64'(valids),      64'd3);
`else
      check_eq("noage stores", 64'(stores), 64'd0);
      check_eq("noage valids", 64'(valids), 64'd4);
`endif
      quiet_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check_eq("final cmd", 64'(mem_cmd), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Sequencing controller that shares the single memory port between cache read-miss fills and write-buffer drains. It sits between the cache, the write buffer and memory. It looks up the buffer first, so that a read hitting a buffered store is forwarded without a memory access. It drives the buffer's `done`/`addr_done` handshake, and it decides read-vs-drain priority with a full-override and an optional aging override.

## Interface
Parameters:
- `ADDR_W`, default `` `MEM_ADDR_SIZE ``: memory address width.
- `DATA_W`, default `` `WORD_SIZE_BIT ``: word width.
- `AGE_LIMIT`, default 15: drain-starvation threshold in cycles; range 1..255; the counter is 8 bits.

Ports:
- Clocking and reset:
  - `clk`  in  1  Single clock; all state changes on posedge.
  - `reset`  in  1  Synchronous, active-high.
- Cache side:
  - `rd_req`  in  1  Read-miss request; held high until `rd_valid`.
  - `rd_addr`  in  ADDR_W  Read address; stable while `rd_req` is high.
  - `rd_valid`  out  1  One-cycle response strobe.
  - `rd_data`  out  DATA_W  Response word; valid while `rd_valid` is high.
- Write-buffer side:
  - `wb_pending`  in  1  Buffer non-empty (`write_out`).
  - `wb_full`  in  1  Buffer full.
  - `wb_addr`  in  ADDR_W  Head entry address.
  - `wb_data`  in  DATA_W  Head entry data.
  - `wb_hit`  in  1  Lookup hit.
  - `wb_hit_data`  in  DATA_W  Lookup data.
  - `wb_read`  out  1  Lookup enable; equals `rd_req` while in IDLE.
  - `wb_lookup_addr`  out  ADDR_W  Equals `rd_addr`.
  - `wb_addr_done`  out  1  Head address accepted by memory.
  - `wb_done`  out  1  Head data accepted; buffer pops.
- Memory side:
  - `mem_cmd`  out  2  Command: 00 none, 01 LOAD, 10 STORE.
  - `mem_addr`  out  ADDR_W  Command address.
  - `mem_wdata`  out  DATA_W  Store data.
  - `mem_addr_ack`  in  1  Address phase accepted.
  - `mem_ack`  in  1  Data phase complete.
  - `mem_rdata`  in  DATA_W  Load data; valid with `mem_ack`.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, RESP. The state register, `age`, the latched read address and the response data are registered.
- IDLE: the first true condition below wins.
  1. `wb_pending & wb_full` goes to WR_ADDR.
  2. `rd_req & wb_hit` latches `wb_hit_data` and goes to RESP.
  3. `rd_req & ~age_expired` latches `rd_addr` and goes to RD_ADDR.
  4. `wb_pending` goes to WR_ADDR.
  5. Otherwise the block stays in IDLE.
- RD_ADDR: `mem_cmd`=01 and `mem_addr`=latched address. `mem_addr_ack` goes to RD_DATA. `mem_addr_ack & mem_ack` in the same cycle latches `mem_rdata` and goes directly to RESP.
- RD_DATA: `mem_cmd`=01. `mem_ack` latches `mem_rdata` and goes to RESP.
- RESP: `rd_valid`=1 and `rd_data`=latched word for exactly one cycle, then IDLE.
- WR_ADDR: `mem_cmd`=10, `mem_addr`=`wb_addr`, `mem_wdata`=`wb_data`.
  - `mem_addr_ack` asserts `wb_addr_done` combinationally in that cycle and goes to WR_DATA.
  - `mem_addr_ack & mem_ack` asserts both strobes and goes to IDLE.
- WR_DATA: `mem_cmd`=10 and `mem_wdata`=`wb_data`. `mem_ack` asserts `wb_done` combinationally and goes to IDLE. Exactly one pop per store.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_cmd`=00. Acks arriving in states that do not expect them are ignored.
- Aging (with `WB_AGE_EN` only):
  - `age` increments, saturating at `AGE_LIMIT`, each cycle `wb_pending`=1 and the state is not WR_*.
  - `age` clears on entry to WR_ADDR or when `wb_pending`=0.
  - `age_expired` = (`age` == `AGE_LIMIT`).
- The cache must not write the address in flight to the buffer during RD_*; this is a cache obligation and is not checked here.

## Timing
- Reset: state IDLE, `age`=0, latches 0. All outputs are 0, except `wb_read` and `wb_lookup_addr`, which follow their combinational definitions.
- Reset mid-transaction abandons it: no `wb_done` and no `rd_valid` is issued, and memory must tolerate the dropped command.
- Buffer-hit read: `rd_req` sampled in IDLE at cycle N gives `rd_valid` at cycle N+1.
- Memory read with immediate acks: `rd_req` at cycle N, RD_ADDR at N+1; with both acks at N+1, `rd_valid` at N+2. Each extra ack-wait cycle adds one cycle.
- Drain: `wb_done` coincides with the `mem_ack` cycle. The buffer updates on negedge, so it samples the combinational strobe in the same cycle.
- After `rd_valid`, `rd_req` may drop at the next edge; a new request is accepted the cycle after RESP.
- Back-to-back drains: at least one IDLE cycle between stores.

## Configuration
- `WB_AGE_EN` defined: the aging counter is present. Once a pending drain has waited `AGE_LIMIT` cycles, it wins over a memory read. It never wins over a buffer-hit read.
- `WB_AGE_EN` undefined: there is no counter, `age_expired` is constant 0, and reads have strict priority except when `wb_full`=1.

## Test plan
- Reset, then idle → all outputs 0, state IDLE; a `reset` pulse during WR_DATA → no `wb_done`, IDLE the next cycle.
- `wb_pending`=1 with `wb_addr`=0x40, `wb_data`=0xDEAD; acks one cycle apart → `mem_cmd`=10, `mem_addr`=0x40, `mem_wdata`=0xDEAD; `wb_addr_done` then `wb_done`, one cycle each.
- `rd_req` with `rd_addr`=0x40 and `wb_hit`=1, `wb_hit_data`=0xDEAD → `rd_valid` the next cycle with 0xDEAD; `mem_cmd` stays 00.
- `rd_req` miss to 0x80 with `wb_pending`=1, `wb_full`=0 → LOAD issued first; `mem_rdata`=0x1234 gives `rd_valid` with 0x1234, then the STORE.
- `wb_full`=1 and `rd_req` miss together → STORE first, then LOAD.
- `WB_AGE_EN`, `AGE_LIMIT`=3, continuous missing reads with `wb_pending`=1 → a STORE is issued no later than the read following the age-3 cycle; without the macro, no STORE until reads stop.
